// File: rtl/sprite_bank_ram_pkg.sv
// Shared types, constants and helpers for the sprite bank RAM: header layout,
// AHB-Lite encodings, default geometry and byte-lane decode.
package sprite_bank_ram_pkg;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPRITE_DIM  = 16;
    localparam int DEF_PIX_WORDS   = DEF_NUM_SPRITES * DEF_SPRITE_DIM * DEF_SPRITE_DIM;
    localparam int DEF_IDX_W       = $clog2(DEF_NUM_SPRITES + DEF_PIX_WORDS);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    typedef struct packed {
        logic        enable;
        logic        flip_x;
        logic        flip_y;
        logic [28:0] attr;
    } sprite_hdr_t;

    // Source of HRDATA during the data phase.
    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_HDR  = 2'd1,
        RD_PIX  = 2'd2
    } rd_sel_e;

    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sprite_bank_ram_if.sv
// AHB-Lite slave-side signal bundle used between the interconnect and the sprite bank.
interface sprite_bank_ram_if;
    // A transfer is accepted in the address phase when HSEL & HREADY & HTRANS!=IDLE;
    // its data phase is the next cycle and ends on the first edge with HREADY high.
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/sprite_bank_ram_pixel_ram.sv
// Pixel storage: port A writes with byte enables and reads a separate address,
// port B is a read-only scan-out port. Reads return the pre-write contents.
module sprite_bank_ram_pixel_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_waddr,
    input  logic [3:0]    i_a_be,
    input  logic [31:0]   i_a_wdata,
    input  logic [AW-1:0] i_a_raddr,
    output logic [31:0]   o_a_rdata,
    input  logic [AW-1:0] i_b_raddr,
    output logic [31:0]   o_b_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_a_be[i]) begin
                    r_mem[i_a_waddr][8*i +: 8] <= i_a_wdata[8*i +: 8];
                end
            end
        end
        o_a_rdata <= r_mem[i_a_raddr];
        o_b_rdata <= r_mem[i_b_raddr];
    end

endmodule

// File: rtl/sprite_bank_ram.sv
// Sprite store on AHB-Lite: double-buffered headers, byte-lane pixel writes with
// read-after-write forwarding, and a one-cycle flip/transparency pixel port.
module sprite_bank_ram
    import sprite_bank_ram_pkg::*;
#(
    parameter int          NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int          SPRITE_DIM  = DEF_SPRITE_DIM,
    parameter logic [31:0] TRANSPARENT = 32'h0,
    localparam int         SLOT_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int         COORD_W     = $clog2(SPRITE_DIM)
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    sprite_bank_ram_if.slave         ahb,
    input  logic                     frame_commit,
    input  logic                     px_req,
    input  logic [SLOT_W-1:0]        px_slot,
    input  logic [COORD_W-1:0]       rel_x,
    input  logic [COORD_W-1:0]       rel_y,
    output logic                     px_valid,
    output logic [31:0]              px_data,
    output logic                     px_opaque,
    output logic [32*NUM_SPRITES-1:0] hdr_active
);

    localparam int PIX_WORDS = NUM_SPRITES * SPRITE_DIM * SPRITE_DIM;
    localparam int MAP_WORDS = NUM_SPRITES + PIX_WORDS;
    localparam int IDX_W     = $clog2(MAP_WORDS);
    localparam int PIX_AW    = $clog2(PIX_WORDS);

    logic [IDX_W-1:0]  w_ap_idx;
    logic              w_ap_accept;
    logic              w_ap_hdr;
    logic              w_ap_pix;
    logic              w_ap_rd;
    logic [PIX_AW-1:0] w_ap_pix_addr;
    logic [3:0]        w_ap_be;
    logic [31:0]       w_dp_mask;
    logic [31:0]       w_ram_a_q;
    logic [31:0]       w_ram_b_q;
    logic [31:0]       w_fwd_mask;

    logic              r_dp_hdr_wr;
    logic              r_dp_pix_wr;
    logic [SLOT_W-1:0] r_dp_slot;
    logic [PIX_AW-1:0] r_dp_pix_addr;
    logic [3:0]        r_dp_be;
    rd_sel_e           r_rd_sel;
    logic [31:0]       r_hdr_rdata;
    logic [31:0]       r_fwd_data;
    logic [3:0]        r_fwd_be;

    sprite_hdr_t       r_shadow [NUM_SPRITES];
    sprite_hdr_t       r_active [NUM_SPRITES];
    sprite_hdr_t       w_shadow_nxt [NUM_SPRITES];

    sprite_hdr_t       w_px_hdr;
    logic              w_px_slot_ok;
    logic [COORD_W-1:0] w_px_x;
    logic [COORD_W-1:0] w_px_y;
    logic [PIX_AW-1:0] w_px_addr;
    logic              r_px_valid;
    logic              r_px_en;
    logic              w_unused;

    assign w_ap_idx      = ahb.HADDR[IDX_W+1:2];
    assign w_ap_accept   = ahb.HSEL & ahb.HREADY & (ahb.HTRANS != HTRANS_IDLE);
    assign w_ap_rd       = w_ap_accept & ~ahb.HWRITE;
    assign w_ap_hdr      = (w_ap_idx < IDX_W'(NUM_SPRITES));
    assign w_ap_pix      = !w_ap_hdr && ({1'b0, w_ap_idx} < (IDX_W+1)'(MAP_WORDS));
    assign w_ap_pix_addr = PIX_AW'(w_ap_idx - IDX_W'(NUM_SPRITES));
    assign w_ap_be       = byte_enables(ahb.HSIZE, ahb.HADDR[1:0]);
    assign w_dp_mask     = lane_mask(r_dp_be);
    assign w_fwd_mask    = lane_mask(r_fwd_be);
    assign w_unused      = ^{ahb.HADDR[31:IDX_W+2], w_px_hdr.attr};

    assign ahb.HREADYOUT = 1'b1;

    // Shadow as it will be after this edge; header reads see it so a
    // back-to-back write then read of the same header is never stale.
    always_comb begin
        for (int s = 0; s < NUM_SPRITES; s++) begin
            w_shadow_nxt[s] = r_shadow[s];
            if (r_dp_hdr_wr && (r_dp_slot == SLOT_W'(s))) begin
                w_shadow_nxt[s] = (r_shadow[s] & ~w_dp_mask) | (ahb.HWDATA & w_dp_mask);
            end
        end
    end

    always_comb begin
        ahb.HRDATA = '0;
        case (r_rd_sel)
            RD_HDR:  ahb.HRDATA = r_hdr_rdata;
            RD_PIX:  ahb.HRDATA = (w_ram_a_q & ~w_fwd_mask) | (r_fwd_data & w_fwd_mask);
            default: ahb.HRDATA = '0;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dp_hdr_wr   <= 1'b0;
            r_dp_pix_wr   <= 1'b0;
            r_dp_slot     <= '0;
            r_dp_pix_addr <= '0;
            r_dp_be       <= '0;
            r_rd_sel      <= RD_ZERO;
            r_hdr_rdata   <= '0;
            r_fwd_data    <= '0;
            r_fwd_be      <= '0;
            for (int s = 0; s < NUM_SPRITES; s++) begin
                r_shadow[s] <= '0;
                r_active[s] <= '0;
            end
        end else begin
            r_dp_hdr_wr   <= w_ap_accept & ahb.HWRITE & w_ap_hdr;
            r_dp_pix_wr   <= w_ap_accept & ahb.HWRITE & w_ap_pix;
            r_dp_slot     <= w_ap_idx[SLOT_W-1:0];
            r_dp_pix_addr <= w_ap_pix_addr;
            r_dp_be       <= w_ap_accept ? w_ap_be : 4'b0000;
            r_rd_sel      <= !w_ap_rd ? RD_ZERO : (w_ap_hdr ? RD_HDR : (w_ap_pix ? RD_PIX : RD_ZERO));
            r_hdr_rdata   <= w_shadow_nxt[w_ap_idx[SLOT_W-1:0]];
            r_fwd_data    <= ahb.HWDATA;
            r_fwd_be      <= (r_dp_pix_wr && (r_dp_pix_addr == w_ap_pix_addr)) ? r_dp_be : 4'b0000;
            for (int s = 0; s < NUM_SPRITES; s++) begin
                r_shadow[s] <= w_shadow_nxt[s];
                if (frame_commit) begin
                    r_active[s] <= r_shadow[s];
                end
            end
        end
    end

    generate
        for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hdr_active
            assign hdr_active[32*s +: 32] = r_active[s];
        end
        if (NUM_SPRITES == (1 << SLOT_W)) begin : g_slot_full
            assign w_px_slot_ok = 1'b1;
        end else begin : g_slot_part
            assign w_px_slot_ok = (px_slot < SLOT_W'(NUM_SPRITES));
        end
    endgenerate

    assign w_px_hdr  = w_px_slot_ok ? r_active[px_slot] : '0;
    assign w_px_x    = w_px_hdr.flip_x ? (COORD_W'(SPRITE_DIM - 1) - rel_x) : rel_x;
    assign w_px_y    = w_px_hdr.flip_y ? (COORD_W'(SPRITE_DIM - 1) - rel_y) : rel_y;
    assign w_px_addr = PIX_AW'({px_slot, w_px_y, w_px_x});

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_px_valid <= 1'b0;
            r_px_en    <= 1'b0;
        end else begin
            r_px_valid <= px_req;
            r_px_en    <= px_req & w_px_slot_ok & w_px_hdr.enable;
        end
    end

    assign px_valid  = r_px_valid;
    assign px_opaque = r_px_en && (w_ram_b_q != TRANSPARENT);
    assign px_data   = px_opaque ? w_ram_b_q : 32'h0;

    sprite_bank_ram_pixel_ram #(
        .DEPTH (PIX_WORDS),
        .AW    (PIX_AW)
    ) u_pixel_ram (
        .i_clk     (HCLK),
        .i_a_we    (r_dp_pix_wr),
        .i_a_waddr (r_dp_pix_addr),
        .i_a_be    (r_dp_be),
        .i_a_wdata (ahb.HWDATA),
        .i_a_raddr (w_ap_pix_addr),
        .o_a_rdata (w_ram_a_q),
        .i_b_raddr (w_px_addr),
        .o_b_rdata (w_ram_b_q)
    );

endmodule

// File: tb/tb_sprite_bank_ram.sv
// Self-checking bench for sprite_bank_ram against a word-array model of the sprite map.
module tb_sprite_bank_ram;

    localparam int NUM  = 4;
    localparam int DIM  = 16;
    localparam int PIXW = NUM * DIM * DIM;
    localparam int MAPW = NUM + PIXW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_bank_ram_if ahb();

    logic                frame_commit;
    logic                px_req;
    logic [1:0]          px_slot;
    logic [3:0]          rel_x;
    logic [3:0]          rel_y;
    logic                px_valid;
    logic [31:0]         px_data;
    logic                px_opaque;
    logic [32*NUM-1:0]   hdr_active;

    sprite_bank_ram #(
        .NUM_SPRITES (NUM),
        .SPRITE_DIM  (DIM),
        .TRANSPARENT (32'h0)
    ) dut (
        .HCLK         (clk),
        .HRESET       (rst),
        .ahb          (ahb),
        .frame_commit (frame_commit),
        .px_req       (px_req),
        .px_slot      (px_slot),
        .rel_x        (rel_x),
        .rel_y        (rel_y),
        .px_valid     (px_valid),
        .px_data      (px_data),
        .px_opaque    (px_opaque),
        .hdr_active   (hdr_active)
    );

    // Reference model of the map
    logic [31:0] m_shadow [NUM];
    logic [31:0] m_active [NUM];
    logic [31:0] m_pix [PIXW];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_lane_mask(input logic [2:0] size, input logic [31:0] addr);
        int lo;
        lo = int'(addr[1:0]);
        if (size == 3'd0) return 32'hFF << (8 * lo);
        if (size == 3'd1) return 32'hFFFF << (16 * (lo / 2));
        return 32'hFFFF_FFFF;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        int idx;
        logic [31:0] m;
        idx = int'(addr[12:2]);
        m = ref_lane_mask(size, addr);
        if (idx < NUM) m_shadow[idx] = (m_shadow[idx] & ~m) | (data & m);
        else if (idx < MAPW) m_pix[idx-NUM] = (m_pix[idx-NUM] & ~m) | (data & m);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[12:2]);
        if (idx < NUM) return m_shadow[idx];
        if (idx < MAPW) return m_pix[idx-NUM];
        return 32'h0;
    endfunction

    function automatic void model_commit();
        for (int s = 0; s < NUM; s++) m_active[s] = m_shadow[s];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM; s++) begin
            m_shadow[s] = 32'h0;
            m_active[s] = 32'h0;
        end
    endfunction

    function automatic logic [32*NUM-1:0] model_hdr_flat();
        logic [32*NUM-1:0] v;
        for (int s = 0; s < NUM; s++) v[32*s +: 32] = m_active[s];
        return v;
    endfunction

    function automatic void model_px(input int slot, input int x, input int y,
                                     output logic [31:0] d, output logic o);
        logic [31:0] h;
        logic [31:0] val;
        int xx;
        int yy;
        h = m_active[slot];
        xx = h[30] ? (DIM - 1 - x) : x;
        yy = h[29] ? (DIM - 1 - y) : y;
        val = m_pix[slot*DIM*DIM + yy*DIM + xx];
        o = h[31] && (val != 32'h0);
        d = o ? val : 32'h0;
    endfunction

    // Driver tasks: each starts and ends 1 time unit after a rising edge
    task automatic bus_idle();
        ahb.HSEL = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
        ahb.HSIZE = 3'd2;
        ahb.HADDR = 32'h0;
    endtask

    task automatic bus_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        ahb.HSEL = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = w;
        ahb.HSIZE = sz;
        ahb.HADDR = a;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        bus_addr(a, 1'b1, sz);
        @(posedge clk); #1;
        bus_idle();
        ahb.HWDATA = d;
        @(posedge clk); #1;
        model_write(a, sz, d);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        bus_addr(a, 1'b0, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        d = ahb.HRDATA;
        @(posedge clk); #1;
    endtask

    task automatic b2b_write_read(input logic [31:0] wa, input logic [2:0] sz, input logic [31:0] wd,
                                  input logic [31:0] ra, output logic [31:0] rd, output logic hro);
        bus_addr(wa, 1'b1, sz);
        @(posedge clk); #1;
        ahb.HWDATA = wd;
        bus_addr(ra, 1'b0, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        model_write(wa, sz, wd);
        @(negedge clk);
        rd = ahb.HRDATA;
        hro = ahb.HREADYOUT;
        @(posedge clk); #1;
    endtask

    task automatic commit_pulse();
        frame_commit = 1'b1;
        @(posedge clk); #1;
        frame_commit = 1'b0;
        model_commit();
    endtask

    task automatic px_sample(input int slot, input int x, input int y,
                             output logic v, output logic [31:0] d, output logic o);
        px_req = 1'b1;
        px_slot = 2'(slot);
        rel_x = 4'(x);
        rel_y = 4'(y);
        @(posedge clk); #1;
        px_req = 1'b0;
        @(negedge clk);
        v = px_valid;
        d = px_data;
        o = px_opaque;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        ahb.HREADY = 1'b1;
        ahb.HWDATA = 32'h0;
        frame_commit = 1'b0;
        px_req = 1'b0;
        px_slot = 2'd0;
        rel_x = 4'd0;
        rel_y = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ahb.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want %h", ahb.HRDATA, 32'h0); end
        checks++; if (ahb.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", ahb.HREADYOUT); end
        checks++; if ({px_valid, px_opaque} !== 2'b00) begin errors++; $display("FAIL reset_px_flags: got %b want 00", {px_valid, px_opaque}); end
        checks++; if (px_data !== 32'h0) begin errors++; $display("FAIL reset_px_data: got %h want 0", px_data); end
        checks++; if (hdr_active !== model_hdr_flat()) begin errors++; $display("FAIL reset_hdr_active: got %h want %h", hdr_active, model_hdr_flat()); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fill_pixels();
        for (int i = 0; i < PIXW; i++) begin
            ahb_write(32'((NUM + i) * 4), 3'd2, $urandom);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        ahb_write(32'd16, 3'd2, 32'h1122_3344);
        ahb_write(32'd18, 3'd0, {4{8'hAA}});
        ahb_read(32'd16, d);
        checks++; if (d !== 32'h11AA_3344) begin errors++; $display("FAIL byte_lane: got %h want %h", d, 32'h11AA_3344); end
        ahb_write(32'd20, 3'd2, 32'h0);
        ahb_write(32'd22, 3'd1, 32'hBEEF_BEEF);
        ahb_read(32'd20, d);
        checks++; if (d !== model_read(32'd20)) begin errors++; $display("FAIL half_lane: got %h want %h", d, model_read(32'd20)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic hro;
        b2b_write_read(32'd20, 3'd2, 32'hCAFE_F00D, 32'd20, d, hro);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_word: got %h want %h", d, 32'hCAFE_F00D); end
        checks++; if (hro !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", hro); end
        ahb_write(32'd24, 3'd2, 32'h0102_0304);
        b2b_write_read(32'd25, 3'd0, {4{8'h5A}}, 32'd24, d, hro);
        checks++; if (d !== model_read(32'd24)) begin errors++; $display("FAIL b2b_byte_merge: got %h want %h", d, model_read(32'd24)); end
        b2b_write_read(32'd12, 3'd2, 32'h0BAD_CAFE, 32'd12, d, hro);
        checks++; if (d !== model_read(32'd12)) begin errors++; $display("FAIL b2b_header: got %h want %h", d, model_read(32'd12)); end
    endtask

    task automatic test_commit();
        logic [31:0] d;
        ahb_write(32'd0, 3'd2, 32'h8000_0010);
        checks++; if (hdr_active !== model_hdr_flat()) begin errors++; $display("FAIL commit_before: got %h want %h", hdr_active, model_hdr_flat()); end
        commit_pulse();
        checks++; if (hdr_active[31:0] !== 32'h8000_0010) begin errors++; $display("FAIL commit_first: got %h want %h", hdr_active[31:0], 32'h8000_0010); end
        bus_addr(32'd0, 1'b1, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        ahb.HWDATA = 32'h4000_0003;
        frame_commit = 1'b1;
        @(posedge clk); #1;
        frame_commit = 1'b0;
        model_commit();
        model_write(32'd0, 3'd2, 32'h4000_0003);
        checks++; if (hdr_active !== model_hdr_flat()) begin errors++; $display("FAIL commit_same_edge: got %h want %h", hdr_active, model_hdr_flat()); end
        ahb_read(32'd0, d);
        checks++; if (d !== 32'h4000_0003) begin errors++; $display("FAIL commit_shadow_read: got %h want %h", d, 32'h4000_0003); end
        commit_pulse();
        checks++; if (hdr_active[31:0] !== 32'h4000_0003) begin errors++; $display("FAIL commit_second: got %h want %h", hdr_active[31:0], 32'h4000_0003); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        ahb_write(32'd8, 3'd2, 32'h1234_5678);
        commit_pulse();
        bus_addr(32'd8, 1'b1, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        ahb.HWDATA = 32'hFFFF_FFFF;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (hdr_active !== model_hdr_flat()) begin errors++; $display("FAIL midrst_hdr_active: got %h want %h", hdr_active, model_hdr_flat()); end
        checks++; if ({ahb.HRDATA, px_valid, px_opaque, px_data} !== 66'h0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", {ahb.HRDATA, px_valid, px_opaque, px_data}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ahb_read(32'd8, d);
        checks++; if (d !== model_read(32'd8)) begin errors++; $display("FAIL midrst_dropped: got %h want %h", d, model_read(32'd8)); end
        ahb_write(32'd16, 3'd2, 32'h5566_7788);
        ahb_read(32'd16, d);
        checks++; if (d !== 32'h5566_7788) begin errors++; $display("FAIL midrst_next_write: got %h want %h", d, 32'h5566_7788); end
    endtask

    task automatic test_flip_transparency();
        logic v;
        logic o;
        logic [31:0] d;
        ahb_write(32'((NUM + DIM*DIM + 15) * 4), 3'd2, 32'h00FF_00FF);
        ahb_write(32'((NUM + DIM*DIM) * 4), 3'd2, 32'h0);
        ahb_write(32'd4, 3'd2, 32'hC000_0000);
        commit_pulse();
        px_sample(1, 0, 0, v, d, o);
        checks++; if ({v, o, d} !== {2'b11, 32'h00FF_00FF}) begin errors++; $display("FAIL flip_x_opaque: got %b%b %h want 11 00ff00ff", v, o, d); end
        px_sample(1, 15, 0, v, d, o);
        checks++; if ({v, o, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL flip_x_transparent: got %b%b %h want 10 0", v, o, d); end
        ahb_write(32'd4, 3'd2, 32'hA000_0000);
        commit_pulse();
        px_sample(1, 15, 15, v, d, o);
        checks++; if ({v, o, d} !== {2'b11, 32'h00FF_00FF}) begin errors++; $display("FAIL flip_y: got %b%b %h want 11 00ff00ff", v, o, d); end
        ahb_write(32'd4, 3'd2, 32'h4000_0000);
        commit_pulse();
        px_sample(1, 0, 0, v, d, o);
        checks++; if ({v, o, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL disabled_slot: got %b%b %h want 10 0", v, o, d); end
        @(negedge clk);
        checks++; if ({px_valid, px_opaque, px_data} !== 34'h0) begin errors++; $display("FAIL no_req: got %b%b %h want 00 0", px_valid, px_opaque, px_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [31:0] oor [2];
        int ready_bad;
        oor[0] = 32'(MAPW * 4);
        oor[1] = 32'h1FFC;
        ready_bad = 0;
        for (int k = 0; k < 2; k++) begin
            bus_addr(oor[k], 1'b1, 3'd2);
            @(negedge clk); if (ahb.HREADYOUT !== 1'b1) ready_bad++;
            @(posedge clk); #1;
            bus_idle();
            ahb.HWDATA = 32'hDEAD_BEEF;
            @(negedge clk); if (ahb.HREADYOUT !== 1'b1) ready_bad++;
            @(posedge clk); #1;
            ahb_read(oor[k], d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_read_%0d: got %h want 0", k, d); end
        end
        checks++; if (ready_bad !== 0) begin errors++; $display("FAIL oor_hreadyout: got %0d low cycles want 0", ready_bad); end
        ahb_read(32'((NUM) * 4), d);
        checks++; if (d !== model_read(32'(NUM * 4))) begin errors++; $display("FAIL oor_pixel0: got %h want %h", d, model_read(32'(NUM * 4))); end
        ahb_read(32'((MAPW - 1) * 4), d);
        checks++; if (d !== model_read(32'((MAPW - 1) * 4))) begin errors++; $display("FAIL oor_last: got %h want %h", d, model_read(32'((MAPW - 1) * 4))); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] ed;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  sz;
        logic v;
        logic o;
        logic eo;
        logic hro;
        int idx;
        int lo;
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, NUM - 1);
            else idx = NUM + $urandom_range(0, PIXW - 1);
            sz = 3'($urandom_range(0, 2));
            lo = (sz == 3'd0) ? $urandom_range(0, 3) : ((sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0);
            a = 32'(idx * 4 + lo);
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            case ($urandom_range(0, 4))
                0: ahb_write(a, sz, wd);
                1: begin
                    a = ($urandom_range(0, 7) == 0) ? 32'((MAPW + $urandom_range(0, 1000)) * 4) : 32'(idx * 4);
                    ahb_read(a, d);
                    checks++; if (d !== model_read(a)) begin errors++; $display("FAIL rnd_read @%h: got %h want %h", a, d, model_read(a)); end
                end
                2: begin
                    b2b_write_read(a, sz, wd, 32'(idx * 4), d, hro);
                    checks++; if (d !== model_read(32'(idx * 4))) begin errors++; $display("FAIL rnd_b2b @%h: got %h want %h", a, d, model_read(32'(idx * 4))); end
                end
                3: begin
                    commit_pulse();
                    checks++; if (hdr_active !== model_hdr_flat()) begin errors++; $display("FAIL rnd_commit: got %h want %h", hdr_active, model_hdr_flat()); end
                end
                default: begin
                    idx = $urandom_range(0, NUM - 1);
                    lo = $urandom_range(0, DIM - 1);
                    it = it;
                    begin
                        int y;
                        y = $urandom_range(0, DIM - 1);
                        model_px(idx, lo, y, ed, eo);
                        px_sample(idx, lo, y, v, d, o);
                        checks++; if ({v, o, d} !== {1'b1, eo, ed}) begin errors++; $display("FAIL rnd_px s%0d x%0d y%0d: got %b%b %h want 1%b %h", idx, lo, y, v, o, d, eo, ed); end
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        fill_pixels();
        test_byte_lanes();
        test_back_to_back();
        test_commit();
        test_reset_mid_write();
        test_flip_transparency();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
